vga_display: RTL and testbench

Display-side pixel consumer and 640x480@60 VGA timing generator in the 25 MHz display clock domain. It pops RGB444 pixels from the read port of the 125 MHz→25 MHz CDC FIFO written by the BRAM buffer stage. It emits aligned hsync/vsync/data-enable/RGB to the video DAC pins. FIFO starvation is handled with a fixed fill colour and reported through a sticky flag and a counter.

---
 rtl/vga_display.sv | 173 +++++++++++++++++
 tb/tb_vga_display.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_display.sv
// vga_display: 640x480@60 VGA timing generator and pixel consumer.
// It reads RGB444 pixels from a CDC FIFO read port that has 1-cycle read latency,
// and drives sync, data-enable and colour, all aligned on one clock.
// When the FIFO is starved, the block outputs FILL_RGB, sets a sticky flag and
// bumps a saturating counter.
// Optional feature macro: VGA_TESTPATTERN_EN. It adds i_pattern, a colour-bar source.
module vga_display #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter logic [11:0] FILL_RGB = 12'h000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_rd,
    input  logic [11:0] i_data,
    input  logic        i_empty,
`ifdef VGA_TESTPATTERN_EN
    input  logic        i_pattern,
`endif
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [11:0] o_rgb,
    output logic        o_sof,
    output logic        o_underflow,
    output logic [15:0] o_underflow_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [VW-1:0]   vcnt_q, vcnt_d;
    logic            de_q, de_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            sof_q, sof_d;
    logic            rd_q, rd_d;
    logic            uf_q, uf_d;
    logic [15:0]     uf_cnt_q, uf_cnt_d;
    logic            pattern;
    logic            run;
    logic            active;
    logic            underflow;

`ifdef VGA_TESTPATTERN_EN
    logic            pat_q, pat_d;
    logic [11:0]     pat_rgb_q, pat_rgb_d;
    logic [2:0]      bar;
    assign pattern = i_pattern;
`else
    assign pattern = 1'b0;
`endif

    // Position decode. While the pattern source is selected, the FIFO is not read and underflow is not detected.
    assign run       = (state_q == RUN);
    assign active    = run && (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
    assign o_rd      = active & ~i_empty & ~pattern;
    assign underflow = active & i_empty & ~pattern;

    // Next state and raster counters. The counters stay at 0 until the first pixel is available.
    always_comb begin
        // NOTE: every signal this block drives gets a default first, so no latch can be inferred.
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        case (state_q)
            IDLE: begin
                hcnt_d = '0;
                vcnt_d = '0;
                if (!i_empty || pattern) state_d = RUN;
            end
            RUN: begin
                if (hcnt_q == HW'(H_TOTAL - 1)) begin
                    hcnt_d = '0;
                    vcnt_d = (vcnt_q == VW'(V_TOTAL - 1)) ? '0 : vcnt_q + 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output stage and underflow bookkeeping, computed from the current counter position.
    always_comb begin
        de_d     = active;
        hsync_d  = ~(run && (hcnt_q >= HW'(H_ACTIVE + H_FP))
                         && (hcnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC)));
        vsync_d  = ~(run && (vcnt_q >= VW'(V_ACTIVE + V_FP))
                         && (vcnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC)));
        sof_d    = run && (hcnt_q == '0) && (vcnt_q == '0);
        rd_d     = o_rd;
        uf_d     = uf_q | underflow;
        uf_cnt_d = uf_cnt_q;
        if (underflow && (uf_cnt_q != 16'hFFFF)) uf_cnt_d = uf_cnt_q + 16'd1;
`ifdef VGA_TESTPATTERN_EN
        pat_d     = pattern;
        bar       = 3'(hcnt_q / HW'(H_ACTIVE / 8));
        // The bar order white, yellow, cyan, green, magenta, red, blue, black maps to R=~b1, G=~b2, B=~b0.
        pat_rgb_d = {{4{~bar[1]}}, {4{~bar[2]}}, {4{~bar[0]}}};
`endif
    end

    // State, counter and output registers. Reset is asynchronous, so outputs drop immediately when it asserts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            de_q      <= 1'b0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            sof_q     <= 1'b0;
            rd_q      <= 1'b0;
            uf_q      <= 1'b0;
            uf_cnt_q  <= '0;
`ifdef VGA_TESTPATTERN_EN
            pat_q     <= 1'b0;
            pat_rgb_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so all flops sample the pre-edge values together.
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            de_q      <= de_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            sof_q     <= sof_d;
            rd_q      <= rd_d;
            uf_q      <= uf_d;
            uf_cnt_q  <= uf_cnt_d;
`ifdef VGA_TESTPATTERN_EN
            pat_q     <= pat_d;
            pat_rgb_q <= pat_rgb_d;
`endif
        end
    end

    // Colour mux. FIFO data arrives one cycle after o_rd, which puts it in the same cycle as the registered o_de.
    always_comb begin
        o_rgb = 12'h000;
        if (de_q) begin
            o_rgb = rd_q ? i_data : FILL_RGB;
`ifdef VGA_TESTPATTERN_EN
            if (pat_q) o_rgb = pat_rgb_q;
`endif
        end
    end

    assign o_de            = de_q;
    assign o_hsync         = hsync_q;
    assign o_vsync         = vsync_q;
    assign o_sof           = sof_q;
    assign o_underflow     = uf_q;
    assign o_underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_vga_display.sv
// Testbench for vga_display. It uses a reduced raster so that whole frames finish quickly.
// A queue-based FIFO feeds the DUT. The reference model tracks a flat pixel index
// within the frame and derives the expected outputs from it arithmetically.
module tb_vga_display;

    localparam int HA = 32, HF = 4, HS = 6, HB = 6;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic [11:0] FILL = 12'h5A3;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        o_rd;
    logic [11:0] i_data = 12'h000;
    logic        i_empty = 1'b1;
    logic        pat = 1'b0;
    logic        o_hsync, o_vsync, o_de, o_sof, o_underflow;
    logic [11:0] o_rgb;
    logic [15:0] o_underflow_cnt;

    always #20 clk = ~clk;

    vga_display #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FILL_RGB(FILL)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .o_rd           (o_rd),
        .i_data         (i_data),
        .i_empty        (i_empty),
`ifdef VGA_TESTPATTERN_EN
        .i_pattern      (pat),
`endif
        .o_hsync        (o_hsync),
        .o_vsync        (o_vsync),
        .o_de           (o_de),
        .o_rgb          (o_rgb),
        .o_sof          (o_sof),
        .o_underflow    (o_underflow),
        .o_underflow_cnt(o_underflow_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Bench-side FIFO contents, plus a flag that forces the FIFO to look empty.
    logic [11:0] fifo[$];
    bit          hold_empty = 1'b0;

    // Reference model state. m_pos is the flat pixel index (line*HT + pixel) the DUT is at.
    bit          m_run;
    int          m_pos;
    logic        m_de, m_hs, m_vs, m_sof, m_uf;
    logic [11:0] m_rgb;
    int          m_cnt;

    function automatic logic [11:0] bar_rgb(input int h);
        logic [11:0] bars [8];
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        return bars[h / (HA / 8)];
    endfunction

    task automatic model_reset();
        m_run = 1'b0; m_pos = 0;
        m_de = 1'b0; m_hs = 1'b1; m_vs = 1'b1; m_sof = 1'b0; m_rgb = 12'h000;
        m_uf = 1'b0; m_cnt = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd"},    o_rd, 0);
        check({tag, "_hs"},    o_hsync, 1);
        check({tag, "_vs"},    o_vsync, 1);
        check({tag, "_de"},    o_de, 0);
        check({tag, "_rgb"},   o_rgb, 0);
        check({tag, "_sof"},   o_sof, 0);
        check({tag, "_uf"},    o_underflow, 0);
        check({tag, "_ufcnt"}, o_underflow_cnt, 0);
    endtask

    // One clock: check outputs, choose inputs, check o_rd, advance the model, then present read data.
    task automatic cycle(input int push_pct, input int starve_pct);
        int          h, v;
        bit          active, exp_rd;
        logic [11:0] popped;
        @(negedge clk);
        check("de", o_de, m_de);
        check("rgb", o_rgb, m_rgb);
        check("hsync", o_hsync, m_hs);
        check("vsync", o_vsync, m_vs);
        check("sof", o_sof, m_sof);
        check("uf", o_underflow, m_uf);
        check("ufcnt", o_underflow_cnt, m_cnt);
        if ($urandom_range(99) < push_pct) fifo.push_back(12'($urandom));
        i_empty = hold_empty || ($urandom_range(99) < starve_pct) || (fifo.size() == 0);
        #1;
        h      = m_pos % HT;
        v      = m_pos / HT;
        active = m_run && h < HA && v < VA;
        exp_rd = !i_rst && active && !i_empty && !pat;
        check("rd", o_rd, exp_rd);
        popped = 12'h000;
        if (exp_rd) popped = fifo.pop_front();
        if (i_rst) begin
            model_reset();
        end else if (!m_run) begin
            if (!i_empty || pat) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else begin
            m_de  = active;
            m_hs  = !(h >= HA + HF && h < HA + HF + HS);
            m_vs  = !(v >= VA + VF && v < VA + VF + VS);
            m_sof = (m_pos == 0);
            m_rgb = !active ? 12'h000 : pat ? bar_rgb(h) : exp_rd ? popped : FILL;
            if (active && i_empty && !pat) begin
                m_uf = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end
            m_pos = (m_pos + 1) % FT;
        end
        @(posedge clk);
        #1;
        i_data = exp_rd ? popped : 12'($urandom);
    endtask

    // Run cycles until the model reaches a given flat position. An expired budget counts as a failure.
    task automatic run_to(input int pos, input int push_pct);
        int n = 0;
        while (!(m_run && m_pos == pos) && n < 2 * FT) begin
            cycle(push_pct, 0);
            n++;
        end
        check("reach_pos", n < 2 * FT, 1);
    endtask

    initial begin
        model_reset();
        // Hold reset with the FIFO empty: outputs stay at reset values and o_rd never rises.
        repeat (10) cycle(0, 0);
        check_reset_values("rst");
        i_rst = 1'b0;
        repeat (5) cycle(0, 0);
        check("idle_held", m_run, 0);

        // First line: preload an ascending ramp, then let the raster start.
        for (int i = 1; i <= HA; i++) fifo.push_back(12'(i));
        repeat (2 * FT) cycle(100, 0);

        // Directed starvation on line 3, pixels 10..14.
        run_to(3 * HT + 10, 100);
        hold_empty = 1'b1;
        repeat (5) cycle(100, 0);
        hold_empty = 1'b0;
        repeat (HT) cycle(100, 0);

        // Random FIFO fill and random starvation.
        repeat (2 * FT) cycle(60, 5);

`ifdef VGA_TESTPATTERN_EN
        pat = 1'b1;
        repeat (FT) cycle(60, 20);
        pat = 1'b0;
        repeat (HT) cycle(100, 0);
`endif

        // Mid-frame asynchronous reset at line 5, pixel 10.
        run_to(5 * HT + 10, 100);
        #5 i_rst = 1'b1;
        #1 check_reset_values("midrst");
        model_reset();
        repeat (4) cycle(100, 0);
        i_rst = 1'b0;
        repeat (FT + HT) cycle(100, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
